// File: rtl/minesweeper_pkg.sv
// Shared timing limits and BCD digit type for the minesweeper score/timer slice.
package minesweeper_pkg;

  localparam int TIME_W   = 10;
  localparam int MAX_TIME = 999;

  typedef struct packed {
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] one;
  } bcd3_t;

  localparam bcd3_t BCD_MAX = '{hun: 4'd9, ten: 4'd9, one: 4'd9};

endpackage

// File: rtl/minesweeper_bcd_counter.sv
// Three-digit BCD seconds counter: clear, increment, saturate at 9-9-9.
// Only built when SCORE_BCD_EN is defined.
`ifdef SCORE_BCD_EN
module minesweeper_bcd_counter
  import minesweeper_pkg::*;
(
  input  logic  clk,
  input  logic  i_rst_n,
  input  logic  i_clr,
  input  logic  i_inc,
  output bcd3_t o_count
);

  bcd3_t r_count;

  always_ff @(posedge clk) begin
    if (!i_rst_n || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != BCD_MAX)) begin
      if (r_count.one != 4'd9) begin
        r_count.one <= r_count.one + 4'd1;
      end else begin
        r_count.one <= 4'd0;
        if (r_count.ten != 4'd9) begin
          r_count.ten <= r_count.ten + 4'd1;
        end else begin
          r_count.ten <= 4'd0;
          r_count.hun <= r_count.hun + 4'd1;
        end
      end
    end
  end

  assign o_count = r_count;

endmodule
`endif

// File: rtl/minesweeper_score_timer.sv
// Minesweeper game timer, board-clear hold counter and best-time register.
// Define SCORE_BCD_EN to add 3-digit BCD copies of elapsed and high_score.
module minesweeper_score_timer
  import minesweeper_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int CLEAR_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              reset_out,
  input  logic              clock_run,
  input  logic              compare_high_score,
  output logic              many_cycles,
  output logic [TIME_W-1:0] elapsed,
  output logic [TIME_W-1:0] high_score,
  output logic              high_score_valid,
`ifdef SCORE_BCD_EN
  output logic [11:0]       elapsed_bcd,
  output logic [11:0]       high_score_bcd,
`endif
  output logic              new_record
);

  localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CW-1:0]     r_clr_cnt;
  logic [PW-1:0]     r_presc;
  logic [TIME_W-1:0] r_elapsed;
  logic [TIME_W-1:0] r_high_score;
  logic              r_valid;
  logic              r_new_record;
  logic              r_cmp_q;
  logic              w_tick;
  logic              w_fire;
  logic              w_record;

  assign w_tick   = clock_run && reset_out && (r_presc == PW'(CLK_HZ - 1));
  assign w_fire   = compare_high_score && !r_cmp_q;
  assign w_record = !r_valid || (r_elapsed < r_high_score);

  always_ff @(posedge clk) begin
    if (!reset_in) begin
      r_clr_cnt <= '0;
    end else if (reset_out) begin
      r_clr_cnt <= '0;
    end else if (r_clr_cnt != CW'(CLEAR_CYCLES - 1)) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  assign many_cycles = !reset_out && (r_clr_cnt == CW'(CLEAR_CYCLES - 1));

  // Prescaler keeps running past the 999 s ceiling; only elapsed stops.
  always_ff @(posedge clk) begin
    if (!reset_in || !reset_out) begin
      r_presc   <= '0;
      r_elapsed <= '0;
    end else if (clock_run) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick && (r_elapsed != TIME_W'(MAX_TIME))) begin
        r_elapsed <= r_elapsed + 1'b1;
      end
    end
  end

  // The edge detector tracks the input even during a board clear, so a win
  // level held across the clear cannot fire a second time.
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      r_cmp_q      <= 1'b0;
      r_high_score <= '0;
      r_valid      <= 1'b0;
      r_new_record <= 1'b0;
    end else begin
      r_cmp_q <= compare_high_score;
      if (!reset_out) begin
        r_new_record <= 1'b0;
      end else if (w_fire) begin
        r_new_record <= w_record;
        if (w_record) begin
          r_high_score <= r_elapsed;
          r_valid      <= 1'b1;
        end
      end
    end
  end

  assign elapsed          = r_elapsed;
  assign high_score       = r_high_score;
  assign high_score_valid = r_valid;
  assign new_record       = r_new_record;

`ifdef SCORE_BCD_EN
  bcd3_t w_el_bcd;
  bcd3_t r_hs_bcd;

  minesweeper_bcd_counter u_bcd (
    .clk     (clk),
    .i_rst_n (reset_in),
    .i_clr   (!reset_out),
    .i_inc   (w_tick),
    .o_count (w_el_bcd)
  );

  always_ff @(posedge clk) begin
    if (!reset_in) begin
      r_hs_bcd <= '0;
    end else if (reset_out && w_fire && w_record) begin
      r_hs_bcd <= w_el_bcd;
    end
  end

  assign elapsed_bcd    = w_el_bcd;
  assign high_score_bcd = r_hs_bcd;
`endif

endmodule

// File: tb/tb_minesweeper_score_timer.sv
// Self-checking bench for minesweeper_score_timer (CLK_HZ=4, CLEAR_CYCLES=4).
module tb_minesweeper_score_timer;

  localparam int HZ = 4;
  localparam int CC = 4;

  logic       clk = 1'b0;
  logic       reset_in = 1'b0;
  logic       reset_out = 1'b1;
  logic       clock_run = 1'b0;
  logic       cmp = 1'b0;
  logic       many_cycles;
  logic [9:0] elapsed;
  logic [9:0] high_score;
  logic       high_score_valid;
  logic       new_record;
`ifdef SCORE_BCD_EN
  logic [11:0] elapsed_bcd;
  logic [11:0] high_score_bcd;
`endif

  minesweeper_score_timer #(.CLK_HZ(HZ), .CLEAR_CYCLES(CC)) dut (
    .clk                (clk),
    .reset_in           (reset_in),
    .reset_out          (reset_out),
    .clock_run          (clock_run),
    .compare_high_score (cmp),
    .many_cycles        (many_cycles),
    .elapsed            (elapsed),
    .high_score         (high_score),
    .high_score_valid   (high_score_valid),
`ifdef SCORE_BCD_EN
    .elapsed_bcd        (elapsed_bcd),
    .high_score_bcd     (high_score_bcd),
`endif
    .new_record         (new_record)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: run cycles since the last clear, length of the current
  // low streak on reset_out, and the recorded best time.
  int m_streak = 0;
  int m_run = 0;
  int m_hs = 0;
  int m_valid = 0;
  int m_nr = 0;
  int m_prev = 0;
  int exp_mc = 0;
  logic seen_mc;

  function automatic int m_el();
    return (m_run / HZ > 999) ? 999 : m_run / HZ;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic cycle(input logic ro, input logic cr, input logic ch);
    int fire;
    int e;
    reset_in = 1'b1; reset_out = ro; clock_run = cr; cmp = ch;
    #1;
    seen_mc = many_cycles;
    exp_mc = ((ro ? 0 : m_streak + 1) >= CC) ? 1 : 0;
    @(posedge clk);
    fire = (ch && m_prev == 0) ? 1 : 0;
    m_prev = ch ? 1 : 0;
    if (!ro) begin
      m_run = 0; m_nr = 0; m_streak = m_streak + 1;
    end else begin
      if (fire != 0) begin
        e = m_el();
        if (m_valid == 0 || e < m_hs) begin
          m_hs = e; m_valid = 1; m_nr = 1;
        end else begin
          m_nr = 0;
        end
      end
      if (cr) m_run = m_run + 1;
      m_streak = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset_in = 1'b0;
    reset_out = 1'($urandom_range(0, 1));
    clock_run = 1'($urandom_range(0, 1));
    cmp = 1'($urandom_range(0, 1));
    @(posedge clk);
    m_streak = 0; m_run = 0; m_hs = 0; m_valid = 0; m_nr = 0; m_prev = 0;
    #1;
    reset_in = 1'b1; reset_out = 1'b1; clock_run = 1'b0; cmp = 1'b0;
  endtask

  task automatic clear_board();
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b0);
    do_reset();
    #1;
    n_cmp++; if (elapsed !== 10'd0) begin $display("FAIL reset_elapsed got %0d want 0", elapsed); n_fail++; end
    n_cmp++; if (high_score !== 10'd0) begin $display("FAIL reset_hs got %0d want 0", high_score); n_fail++; end
    n_cmp++; if (high_score_valid !== 1'b0) begin $display("FAIL reset_valid got %0b want 0", high_score_valid); n_fail++; end
    n_cmp++; if (new_record !== 1'b0) begin $display("FAIL reset_nr got %0b want 0", new_record); n_fail++; end
    n_cmp++; if (many_cycles !== 1'b0) begin $display("FAIL reset_mc got %0b want 0", many_cycles); n_fail++; end
  endtask

  task automatic test_clear_hold();
    int pat[6] = '{0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (seen_mc !== 1'(pat[i]) || exp_mc != pat[i]) begin
        $display("FAIL clear_hold[%0d] got %0b want %0d", i, seen_mc, pat[i]); n_fail++;
      end
    end
    cycle(1'b1, 1'b0, 1'b0);
    n_cmp++; if (seen_mc !== 1'b0) begin $display("FAIL clear_rise_mc got %0b want 0", seen_mc); n_fail++; end
  endtask

  task automatic test_timer_pause();
    repeat (12) cycle(1'b1, 1'b1, 1'b0);
    n_cmp++; if (elapsed !== 10'd3 || m_el() != 3) begin $display("FAIL run12 got %0d want 3", elapsed); n_fail++; end
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    n_cmp++; if (elapsed !== 10'd3) begin $display("FAIL pause got %0d want 3", elapsed); n_fail++; end
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    n_cmp++; if (elapsed !== 10'd3) begin $display("FAIL resume3 got %0d want 3", elapsed); n_fail++; end
    cycle(1'b1, 1'b1, 1'b0);
    n_cmp++; if (elapsed !== 10'd4) begin $display("FAIL resume4 got %0d want 4", elapsed); n_fail++; end
  endtask

  task automatic win_at(input int secs, input int hs_want, input logic nr_want, input string tag);
    clear_board();
    repeat (secs * HZ) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (high_score !== 10'(hs_want) || m_hs != hs_want) begin
      $display("FAIL %s_hs got %0d want %0d", tag, high_score, hs_want); n_fail++;
    end
    n_cmp++;
    if (new_record !== nr_want || m_nr != int'(nr_want)) begin
      $display("FAIL %s_nr got %0b want %0b", tag, new_record, nr_want); n_fail++;
    end
    n_cmp++; if (high_score_valid !== 1'b1) begin $display("FAIL %s_valid got %0b want 1", tag, high_score_valid); n_fail++; end
`ifdef SCORE_BCD_EN
    n_cmp++; if (high_score_bcd !== to_bcd(hs_want)) begin $display("FAIL %s_hsbcd got %h want %h", tag, high_score_bcd, to_bcd(hs_want)); n_fail++; end
`endif
    cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_high_score();
    win_at(7, 7, 1'b1, "win7");
    win_at(9, 7, 1'b0, "win9");
    win_at(5, 5, 1'b1, "win5");
    win_at(5, 5, 1'b0, "tie5");
  endtask

  task automatic test_same_cycle();
    clear_board();
    repeat (19) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    n_cmp++; if (high_score !== 10'd4) begin $display("FAIL tickcmp_hs got %0d want 4", high_score); n_fail++; end
    n_cmp++; if (elapsed !== 10'd5) begin $display("FAIL tickcmp_el got %0d want 5", elapsed); n_fail++; end
    n_cmp++; if (new_record !== 1'b1) begin $display("FAIL tickcmp_nr got %0b want 1", new_record); n_fail++; end
    cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_level_hold();
    clear_board();
    repeat (2 * HZ) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    n_cmp++; if (high_score !== 10'd2) begin $display("FAIL hold_first got %0d want 2", high_score); n_fail++; end
    cycle(1'b0, 1'b0, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 1'b1);
    n_cmp++; if (high_score !== 10'd2 || new_record !== 1'b0) begin
      $display("FAIL hold_refire hs %0d nr %0b want 2 0", high_score, new_record); n_fail++;
    end
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    n_cmp++; if (high_score !== 10'd2 || new_record !== 1'b0) begin
      $display("FAIL fire_in_clear hs %0d nr %0b want 2 0", high_score, new_record); n_fail++;
    end
    cycle(1'b1, 1'b0, 1'b1);
    n_cmp++; if (high_score !== 10'(m_hs) || new_record !== 1'(m_nr)) begin
      $display("FAIL after_clear_fire hs %0d nr %0b want %0d %0d", high_score, new_record, m_hs, m_nr); n_fail++;
    end
    cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic ro, cr, ch;
    ch = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      ro = ($urandom_range(0, 24) != 0);
      cr = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) ch = ~ch;
      cycle(ro, cr, ch);
      n_cmp++;
      if (seen_mc !== 1'(exp_mc) || elapsed !== 10'(m_el()) || high_score !== 10'(m_hs) ||
          high_score_valid !== 1'(m_valid) || new_record !== 1'(m_nr)) begin
        $display("FAIL rand[%0d] mc %0b el %0d hs %0d v %0b nr %0b want %0d %0d %0d %0d %0d",
                 i, seen_mc, elapsed, high_score, high_score_valid, new_record,
                 exp_mc, m_el(), m_hs, m_valid, m_nr);
        n_fail++;
      end
`ifdef SCORE_BCD_EN
      n_cmp++;
      if (elapsed_bcd !== to_bcd(m_el())) begin $display("FAIL rand_bcd[%0d] got %h want %h", i, elapsed_bcd, to_bcd(m_el())); n_fail++; end
`endif
    end
    cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    clear_board();
    repeat (999 * HZ - 1) cycle(1'b1, 1'b1, 1'b0);
    n_cmp++; if (elapsed !== 10'd998) begin $display("FAIL sat_pre got %0d want 998", elapsed); n_fail++; end
    cycle(1'b1, 1'b1, 1'b0);
    n_cmp++; if (elapsed !== 10'd999) begin $display("FAIL sat_hit got %0d want 999", elapsed); n_fail++; end
    repeat (8) cycle(1'b1, 1'b1, 1'b0);
    n_cmp++; if (elapsed !== 10'd999 || m_el() != 999) begin $display("FAIL sat_hold got %0d want 999", elapsed); n_fail++; end
`ifdef SCORE_BCD_EN
    n_cmp++; if (elapsed_bcd !== 12'h999) begin $display("FAIL sat_bcd got %h want 999", elapsed_bcd); n_fail++; end
`endif
  endtask

  task automatic test_reset_midgame();
    clear_board();
    repeat (2 * HZ) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    n_cmp++; if (high_score_valid !== 1'b1) begin $display("FAIL mid_pre_valid got %0b want 1", high_score_valid); n_fail++; end
    do_reset();
    #1;
    n_cmp++;
    if (elapsed !== 10'd0 || high_score !== 10'd0 || high_score_valid !== 1'b0 || new_record !== 1'b0) begin
      $display("FAIL mid_reset el %0d hs %0d v %0b nr %0b want 0 0 0 0",
               elapsed, high_score, high_score_valid, new_record);
      n_fail++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_clear_hold();
    test_timer_pause();
    test_high_score();
    test_same_cycle();
    test_level_hold();
    test_random();
    test_saturate();
    test_reset_midgame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
